// File: rtl/game_collision_ctrl_pkg.sv
// game_collision_ctrl_pkg: state encodings, default tuning values and width helper for the collision controller.
package game_collision_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_RUN = 2'd2, ST_OVER = 2'd3} state_t;
  localparam int OVERLAP_MIN_DEF  = 3;
  localparam int SCORE_DIV_DEF    = 4;
  localparam int RESET_FRAMES_DEF = 2;
  localparam int SCORE_W_DEF      = 32;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/game_collision_ctrl_if.sv
// game_collision_ctrl_if: obstacle pixel stream into the controller and stop/reset/score back to the generator.
interface game_collision_ctrl_if #(parameter int SCORE_W = 32);
  logic               pix_en;
  logic               frame_tick;
  logic               bean;
  logic               goose;
  logic               stop;
  logic               game_reset;
  logic [SCORE_W-1:0] score;
  modport master(output pix_en, frame_tick, bean, goose, input stop, game_reset, score);
  modport slave(input pix_en, frame_tick, bean, goose, output stop, game_reset, score);
endinterface

// File: rtl/game_collision_ctrl_btn_press_sync.sv
// btn_press_sync: 2-FF synchroniser on |button with a rising-edge press pulse.
module btn_press_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] button,
  output logic       press
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= |button;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign press = s2_q & ~prev_q;
endmodule

// File: rtl/game_collision_ctrl.sv
// game_collision_ctrl: game-state FSM, per-frame goose/bean overlap hit detection and score counter.
module game_collision_ctrl
  import game_collision_ctrl_pkg::*;
#(
  parameter int OVERLAP_MIN  = OVERLAP_MIN_DEF,
  parameter int SCORE_DIV    = SCORE_DIV_DEF,
  parameter int RESET_FRAMES = RESET_FRAMES_DEF,
  parameter int SCORE_W      = SCORE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            button,
  output logic [1:0]            state,
  game_collision_ctrl_if.slave  bus
);
  localparam int OW = $clog2(OVERLAP_MIN + 1);
  localparam int FW = $clog2(max2(SCORE_DIV, RESET_FRAMES) + 1);
  state_t             st_q, st_d;
  logic               stop_q, stop_d, gr_q, gr_d;
  logic [OW-1:0]      ovl_q, ovl_d;
  logic [FW-1:0]      frm_q, frm_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               press, hit, start_last, div_wrap;
  btn_press_sync u_btn (.clk(clk), .reset_n(reset_n), .button(button), .press(press));
  assign hit        = ovl_q >= OW'(OVERLAP_MIN);
  assign start_last = frm_q == FW'(RESET_FRAMES - 1);
  assign div_wrap   = frm_q == FW'(SCORE_DIV - 1);
  always_comb begin
    st_d    = st_q;
    frm_d   = frm_q;
    score_d = score_q;
    ovl_d   = (st_q != ST_RUN || bus.frame_tick) ? '0 :
              (bus.pix_en && bus.bean && bus.goose && !hit) ? ovl_q + OW'(1) : ovl_q;
    case (st_q)
      ST_IDLE, ST_OVER: if (press) begin
        st_d    = ST_START;
        frm_d   = '0;
        score_d = '0;
      end
      ST_START: if (bus.frame_tick) begin
        st_d  = start_last ? ST_RUN : ST_START;
        frm_d = start_last ? '0 : frm_q + FW'(1);
      end
      ST_RUN: if (bus.frame_tick) begin
        // a hit on the frame that would score takes priority over the increment
        st_d    = hit ? ST_OVER : ST_RUN;
        frm_d   = hit ? frm_q : div_wrap ? '0 : frm_q + FW'(1);
        score_d = (!hit && div_wrap && !(&score_q)) ? score_q + SCORE_W'(1) : score_q;
      end
    endcase
    stop_d = st_d == ST_IDLE || st_d == ST_OVER;
    gr_d   = st_d == ST_IDLE || st_d == ST_START;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ST_IDLE;
      stop_q  <= 1'b1;
      gr_q    <= 1'b1;
      ovl_q   <= '0;
      frm_q   <= '0;
      score_q <= '0;
    end else begin
      st_q    <= st_d;
      stop_q  <= stop_d;
      gr_q    <= gr_d;
      ovl_q   <= ovl_d;
      frm_q   <= frm_d;
      score_q <= score_d;
    end
  end
  assign state          = st_q;
  assign bus.stop       = stop_q;
  assign bus.game_reset = gr_q;
  assign bus.score      = score_q;
endmodule

// File: tb/tb_game_collision_ctrl.sv
// tb_game_collision_ctrl: frame-level vectors with a scoreboard queue, plus hand sequences for hit latency and async reset.
module tb_game_collision_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic       pix_en = 1'b0, frame_tick = 1'b0, bean = 1'b0, goose = 1'b0;
  logic [1:0] state_a, state_b;
  logic       pre_stop;
  int         pass_cnt = 0, total_cnt = 0;
  typedef struct {
    int          k;
    bit          press;
    logic [1:0]  st;
    logic        stp;
    logic        gr;
    logic [31:0] sc;
  } vec_t;
  vec_t rows[$];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  game_collision_ctrl_if #(.SCORE_W(32)) bus_a ();
  game_collision_ctrl_if #(.SCORE_W(4))  bus_b ();
  assign bus_a.pix_en = pix_en;
  assign bus_a.frame_tick = frame_tick;
  assign bus_a.bean = bean;
  assign bus_a.goose = goose;
  assign bus_b.pix_en = pix_en;
  assign bus_b.frame_tick = frame_tick;
  assign bus_b.bean = bean;
  assign bus_b.goose = goose;
  game_collision_ctrl #(.OVERLAP_MIN(3), .SCORE_DIV(4), .RESET_FRAMES(2), .SCORE_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .button(button), .state(state_a), .bus(bus_a));
  game_collision_ctrl #(.OVERLAP_MIN(3), .SCORE_DIV(4), .RESET_FRAMES(2), .SCORE_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .button(button), .state(state_b), .bus(bus_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // 10 visible pixels (first k overlapping, one bean-only, one goose-only), an off-screen overlap, then frame_tick
  task automatic run_frame(input int k, input bit press);
    for (int i = 0; i < 12; i++) begin
      pix_en     = i < 10;
      bean       = i < k || i == 8 || i == 10;
      goose      = i < k || i == 9 || i == 10;
      frame_tick = i == 11;
      if (press) button = i < 6 ? 2'b10 : 2'b00;
      if (i == 11) pre_stop = bus_a.stop;
      @(posedge clk); #1;
    end
    pix_en = 0; bean = 0; goose = 0; frame_tick = 0;
  endtask

  task automatic row(input int k, input bit p, input logic [1:0] st, input logic stp, input logic gr,
                     input logic [31:0] sc);
    vec_t v;
    v = '{k, p, st, stp, gr, sc};
    rows.push_back(v);
  endtask

  task automatic run_rows(input string tag);
    vec_t e;
    for (int r = 0; r < rows.size(); r++) begin
      exp_q.push_back(rows[r]);
      run_frame(rows[r].k, rows[r].press);
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d].state", tag, r), {30'd0, state_a}, {30'd0, e.st});
      chk($sformatf("%s[%0d].stop", tag, r), {31'd0, bus_a.stop}, {31'd0, e.stp});
      chk($sformatf("%s[%0d].game_reset", tag, r), {31'd0, bus_a.game_reset}, {31'd0, e.gr});
      chk($sformatf("%s[%0d].score", tag, r), bus_a.score, e.sc);
    end
    rows.delete();
  endtask

  task automatic press_start(input string name);
    int n;
    n = 0;
    button = 2'b01;
    while (state_a != 2'd1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, ".latency"}, n, 3);
    button = 2'b00;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.state", {30'd0, state_a}, 0);
    chk("rst.stop", {31'd0, bus_a.stop}, 1);
    chk("rst.game_reset", {31'd0, bus_a.game_reset}, 1);
    chk("rst.score", bus_a.score, 0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle.state", {30'd0, state_a}, 0);
    press_start("start1");
    chk("start1.game_reset", {31'd0, bus_a.game_reset}, 1);
    chk("start1.stop", {31'd0, bus_a.stop}, 0);
    row(0, 0, 1, 0, 1, 0);
    row(3, 0, 2, 0, 0, 0);
    for (int n = 1; n <= 40; n++) row(0, n == 20, 2, 0, 0, n / 4);
    row(2, 0, 2, 0, 0, 10);
    run_rows("run40");
    run_frame(3, 0);
    chk("hit.pre_stop", {31'd0, pre_stop}, 0);
    chk("hit.stop", {31'd0, bus_a.stop}, 1);
    chk("hit.state", {30'd0, state_a}, 3);
    chk("hit.score", bus_a.score, 10);
    row(0, 0, 3, 1, 0, 10);
    row(3, 0, 3, 1, 0, 10);
    run_rows("over");
    press_start("start2");
    chk("start2.score", bus_a.score, 0);
    row(0, 0, 1, 0, 1, 0);
    row(0, 0, 2, 0, 0, 0);
    for (int n = 1; n <= 7; n++) row(0, 0, 2, 0, 0, n / 4);
    row(3, 0, 3, 1, 0, 1);
    run_rows("hitwins");
    press_start("start3");
    row(0, 0, 1, 0, 1, 0);
    row(0, 0, 2, 0, 0, 0);
    for (int n = 1; n <= 4; n++) row(0, 0, 2, 0, 0, n / 4);
    run_rows("pre_hold");
    button = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    chk("run_press.state", {30'd0, state_a}, 2);
    row(3, 0, 3, 1, 0, 1);
    row(0, 0, 3, 1, 0, 1);
    run_rows("held");
    button = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    chk("held_release.state", {30'd0, state_a}, 3);
    press_start("restart");
    chk("restart.score", bus_a.score, 0);
    row(0, 0, 1, 0, 1, 0);
    row(0, 0, 2, 0, 0, 0);
    for (int n = 1; n <= 64; n++) row(0, 0, 2, 0, 0, n / 4);
    run_rows("sat");
    chk("sat.score_w4", {28'd0, bus_b.score}, 15);
    chk("sat.state_w4", {30'd0, state_b}, 2);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async.state", {30'd0, state_a}, 0);
    chk("async.stop", {31'd0, bus_a.stop}, 1);
    chk("async.game_reset", {31'd0, bus_a.game_reset}, 1);
    chk("async.score", bus_a.score, 0);
    chk("async.score_w4", {28'd0, bus_b.score}, 0);
    #2;
    reset_n = 1'b1;
    run_frame(0, 0);
    chk("post_rst.state", {30'd0, state_a}, 0);
    chk("post_rst.stop", {31'd0, bus_a.stop}, 1);
    press_start("post_rst");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
